// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and helpers for the parametrised FIFO slice.
//   FIFO_DEF_DATA_W / FIFO_DEF_DEPTH : default geometry (8 x 16)
//   fifo_clog2()                      : ceil(log2(n)) usable in constant expressions
//   `FIFO_CNT_W(depth)                : width of an occupancy count able to hold 0..depth
`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV

`define FIFO_CNT_W(depth) (fifo_clog2(depth) + 1)

package fifo_pkg;

   localparam int unsigned FIFO_DEF_DATA_W = 8;
   localparam int unsigned FIFO_DEF_DEPTH  = 16;

   function automatic int unsigned fifo_clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned v = 1; v < n; v = v << 1) r++;
      return r;
   endfunction

endpackage

`endif

// File: rtl/fifo_mem_2p.sv
// fifo_mem_2p: DEPTH x DATA_W storage, one synchronous write port and one
// asynchronous read port. Contents are not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
module fifo_mem_2p #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with count-based flags,
// programmable almost-full/almost-empty thresholds and one-cycle
// overflow/underflow pulses for rejected requests.
//   clk, reset_n (async, active low)
//   wr_en, data_in  : write request and data
//   rd_en, data_out : read request and data
//   full, empty, almost_full, almost_empty, count : occupancy status
//   overflow, underflow : registered one-cycle rejection pulses
// Build option: define FIFO_FWFT_EN for first-word-fall-through output
// (data_out shows the head combinationally, 0 when empty). Default is a
// registered data_out with one cycle read latency.
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_W   = FIFO_DEF_DATA_W,
   parameter int unsigned DEPTH    = FIFO_DEF_DEPTH,
   parameter int unsigned AF_LEVEL = DEPTH - 2,
   parameter int unsigned AE_LEVEL = 2
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            wr_en,
   input  logic [DATA_W-1:0]               data_in,
   input  logic                            rd_en,
   output logic [DATA_W-1:0]               data_out,
   output logic                            full,
   output logic                            empty,
   output logic                            almost_full,
   output logic                            almost_empty,
   output logic [`FIFO_CNT_W(DEPTH)-1:0]   count,
   output logic                            overflow,
   output logic                            underflow
);

   localparam int unsigned ADDR_W = fifo_clog2(DEPTH);
   localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];
   localparam logic [ADDR_W:0] AF_L    = AF_LEVEL[ADDR_W:0];
   localparam logic [ADDR_W:0] AE_L    = AE_LEVEL[ADDR_W:0];
   localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

   logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q,  count_d;
   logic              overflow_q, underflow_q;
   logic              rd_acc, wr_acc;
   logic [DATA_W-1:0] rd_data;

   assign full         = (count_q == DEPTH_L);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= AF_L);
   assign almost_empty = (count_q <= AE_L);
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   // A full FIFO still accepts a write when a read frees the slot in the same cycle.
   assign rd_acc = rd_en & ~empty;
   assign wr_acc = wr_en & (~full | rd_acc);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_acc) wr_ptr_d = wr_ptr_q + ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + ONE;
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + ONE;
         2'b01:   count_d = count_q - ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= wr_en & ~wr_acc;
         underflow_q <= rd_en & ~rd_acc;
      end
   end

   fifo_mem_2p #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr_q[ADDR_W-1:0]),
      .wdata (data_in),
      .raddr (rd_ptr_q[ADDR_W-1:0]),
      .rdata (rd_data)
   );

`ifdef FIFO_FWFT_EN
   assign data_out = empty ? '0 : rd_data;
`else
   logic [DATA_W-1:0] dout_q;

   // Read data is captured before the same-edge write, so read+write on a
   // full FIFO returns the old word even though both address the same slot.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    dout_q <= '0;
      else if (rd_acc) dout_q <= rd_data;
   end

   assign data_out = dout_q;
`endif

endmodule
